// File: rtl/hamming_secded_pipeline.sv
// ----------------------------------------------------------------------------
// hamming_secded_pipeline
//   Three-stage registered Hamming SEC/DED (8,4) datapath:
//     stage 1: encode dato_entrada into an 8-bit codeword. dato_error is
//              registered alongside it so the two stay aligned.
//     stage 2: build the received word by replacing the data bits with
//              dato_error. Compute the syndrome and the overall-parity check.
//     stage 3: correct single errors (including a p0 error) and flag double
//              errors.
//   Codeword bit i holds Hamming position i for i = 1..7, and bit 0 holds the
//   overall parity p0: {d3,d2,d1,p4,d0,p2,p1,p0}.
//   The pipeline accepts one nibble per cycle and has no handshake.
//
// Ports
//   reloj                 in   1  clock, rising edge
//   rst_n                 in   1  asynchronous active-low reset
//   dato_entrada          in   4  nibble to encode
//   dato_error            in   4  nibble as received (error injection)
//   palabra               out  8  encoded codeword              (latency 1)
//   recibido              out  8  received codeword             (latency 2)
//   s1, s2, s3            out  1  syndrome bits 0..2            (latency 2)
//   st                    out  1  overall parity of recibido    (latency 2)
//   error_simple          out  1  single-error flag             (latency 2)
//   error_doble           out  1  double-error flag             (latency 2)
//   corregido             out  4  corrected data nibble         (latency 3)
//   palabra_corregida     out  8  corrected codeword            (latency 3)
//   simplerror_detectado  out  1  single error corrected        (latency 3)
//   doblerror_detectado   out  1  uncorrectable double error    (latency 3)
//   led_doblerror         out  1  LED drive, same as doblerror_detectado
// ----------------------------------------------------------------------------
module hamming_secded_pipeline (
    input  logic       reloj,
    input  logic       rst_n,
    input  logic [3:0] dato_entrada,
    input  logic [3:0] dato_error,
    output logic [7:0] palabra,
    output logic [7:0] recibido,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic       st,
    output logic       error_simple,
    output logic       error_doble,
    output logic [3:0] corregido,
    output logic [7:0] palabra_corregida,
    output logic       simplerror_detectado,
    output logic       doblerror_detectado,
    output logic       led_doblerror
);

    // ---------------- stage 1: encode ----------------
    logic [7:0] w_cod;
    logic [7:0] r_palabra;
    logic [3:0] r_dato_error;

    always_comb begin
        w_cod    = '0;
        w_cod[3] = dato_entrada[0];
        w_cod[5] = dato_entrada[1];
        w_cod[6] = dato_entrada[2];
        w_cod[7] = dato_entrada[3];
        w_cod[1] = dato_entrada[0] ^ dato_entrada[1] ^ dato_entrada[3];
        w_cod[2] = dato_entrada[0] ^ dato_entrada[2] ^ dato_entrada[3];
        w_cod[4] = dato_entrada[1] ^ dato_entrada[2] ^ dato_entrada[3];
        w_cod[0] = ^w_cod[7:1];
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            r_palabra    <= '0;
            r_dato_error <= '0;
        end else begin
            r_palabra    <= w_cod;
            r_dato_error <= dato_error;
        end
    end

    // ---------------- stage 2: receive + syndrome ----------------
    logic [7:0] w_rec;
    logic       w_s1, w_s2, w_s3, w_st;
    logic [7:0] r_recibido;
    logic       r_s1, r_s2, r_s3, r_st;
    logic       r_error_simple, r_error_doble;

    // The parity bits pass through unchanged. Only the data positions take
    // the injected nibble.
    always_comb begin
        w_rec    = r_palabra;
        w_rec[3] = r_dato_error[0];
        w_rec[5] = r_dato_error[1];
        w_rec[6] = r_dato_error[2];
        w_rec[7] = r_dato_error[3];
    end

    assign w_s1 = w_rec[1] ^ w_rec[3] ^ w_rec[5] ^ w_rec[7];
    assign w_s2 = w_rec[2] ^ w_rec[3] ^ w_rec[6] ^ w_rec[7];
    assign w_s3 = w_rec[4] ^ w_rec[5] ^ w_rec[6] ^ w_rec[7];
    assign w_st = ^w_rec;

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            r_recibido     <= '0;
            r_s1           <= 1'b0;
            r_s2           <= 1'b0;
            r_s3           <= 1'b0;
            r_st           <= 1'b0;
            r_error_simple <= 1'b0;
            r_error_doble  <= 1'b0;
        end else begin
            r_recibido     <= w_rec;
            r_s1           <= w_s1;
            r_s2           <= w_s2;
            r_s3           <= w_s3;
            r_st           <= w_st;
            r_error_simple <= w_st;
            r_error_doble  <= (w_s1 | w_s2 | w_s3) & ~w_st;
        end
    end

    // ---------------- stage 3: correct ----------------
    logic [2:0] w_syn;
    logic [7:0] w_corr;
    logic [7:0] r_palabra_corr;
    logic       r_simple_det, r_doble_det;

    assign w_syn = {r_s3, r_s2, r_s1};

    // With odd overall parity, the syndrome gives the bit to flip directly.
    // Syndrome 0 points at bit 0, which is the p0 error case. With even
    // parity, the word is either clean or a double error, and both pass
    // through uncorrected.
    always_comb begin
        w_corr = r_recibido;
        if (r_st)
            w_corr = r_recibido ^ (8'd1 << w_syn);
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            r_palabra_corr <= '0;
            r_simple_det   <= 1'b0;
            r_doble_det    <= 1'b0;
        end else begin
            r_palabra_corr <= w_corr;
            r_simple_det   <= r_error_simple;
            r_doble_det    <= r_error_doble;
        end
    end

    // ---------------- outputs ----------------
    assign palabra              = r_palabra;
    assign recibido             = r_recibido;
    assign s1                   = r_s1;
    assign s2                   = r_s2;
    assign s3                   = r_s3;
    assign st                   = r_st;
    assign error_simple         = r_error_simple;
    assign error_doble          = r_error_doble;
    assign palabra_corregida    = r_palabra_corr;
    assign corregido            = {r_palabra_corr[7], r_palabra_corr[6],
                                   r_palabra_corr[5], r_palabra_corr[3]};
    assign simplerror_detectado = r_simple_det;
    assign doblerror_detectado  = r_doble_det;
    assign led_doblerror        = r_doble_det;

endmodule

// File: tb/tb_hamming_secded_pipeline.sv
// ----------------------------------------------------------------------------
// tb_hamming_secded_pipeline
//   Directed plus random stimulus for hamming_secded_pipeline.
//   Each capture edge pushes an expectation into three stage queues:
//     stage 1 at latency 1, stage 2 at latency 2, stage 3 at latency 3.
//   The negedge that follows pops one entry from each queue and compares it.
//   Known-answer vectors carry literal expectations. Random vectors use a
//   model that encodes by Hamming position and decodes by a nearest-codeword
//   search.
// ----------------------------------------------------------------------------
module tb_hamming_secded_pipeline;

    logic       reloj = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dato_entrada = '0;
    logic [3:0] dato_error   = '0;
    logic [7:0] palabra, recibido, palabra_corregida;
    logic       s1, s2, s3, st, error_simple, error_doble;
    logic [3:0] corregido;
    logic       simplerror_detectado, doblerror_detectado, led_doblerror;

    hamming_secded_pipeline dut (
        .reloj                (reloj),
        .rst_n                (rst_n),
        .dato_entrada         (dato_entrada),
        .dato_error           (dato_error),
        .palabra              (palabra),
        .recibido             (recibido),
        .s1                   (s1),
        .s2                   (s2),
        .s3                   (s3),
        .st                   (st),
        .error_simple         (error_simple),
        .error_doble          (error_doble),
        .corregido            (corregido),
        .palabra_corregida    (palabra_corregida),
        .simplerror_detectado (simplerror_detectado),
        .doblerror_detectado  (doblerror_detectado),
        .led_doblerror        (led_doblerror)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        logic [7:0] rec;
        logic [2:0] syn;
        logic       st;
        logic       es;
        logic       ed;
    } s2_t;

    typedef struct {
        logic [7:0] pc;
        logic [3:0] cor;
        logic       sd;
        logic       dd;
    } s3_t;

    logic [7:0] q1[$];
    s2_t        q2[$];
    s3_t        q3[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_enc(input logic [3:0] d);
        logic [7:0] w;
        w = '0;
        w[3] = d[0]; w[5] = d[1]; w[6] = d[2]; w[7] = d[3];
        // Each parity bit p covers every position whose index has bit p set.
        for (int p = 1; p <= 4; p = p * 2) begin
            logic par;
            par = 1'b0;
            for (int j = 3; j <= 7; j++)
                if ((j & p) != 0) par ^= w[j];
            w[p] = par;
        end
        w[0] = ^w[7:1];
        return w;
    endfunction

    function automatic logic [2:0] m_syn(input logic [7:0] w);
        logic [2:0] s;
        s = '0;
        for (int j = 1; j <= 7; j++)
            if (w[j]) s ^= 3'(j);
        return s;
    endfunction

    function automatic logic [7:0] m_rec(input logic [3:0] din, input logic [3:0] derr);
        logic [7:0] w;
        w = m_enc(din);
        w[3] = derr[0]; w[5] = derr[1]; w[6] = derr[2]; w[7] = derr[3];
        return w;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic push(input logic [7:0] pal, input logic [7:0] rec, input logic [2:0] syn,
                        input logic stv, input logic [7:0] pc, input logic sd, input logic dd);
        s2_t e2;
        s3_t e3;
        e2.rec = rec; e2.syn = syn; e2.st = stv;
        e2.es  = stv;
        e2.ed  = (syn != 3'd0) && !stv;
        e3.pc  = pc;  e3.cor = {pc[7], pc[6], pc[5], pc[3]};
        e3.sd  = sd;  e3.dd  = dd;
        q1.push_back(pal);
        q2.push_back(e2);
        q3.push_back(e3);
    endtask

    task automatic push_model(input logic [3:0] din, input logic [3:0] derr);
        logic [7:0] rec, best;
        int         bd;
        rec  = m_rec(din, derr);
        bd   = 9;
        best = rec;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] c;
            c = m_enc(4'(k));
            if ($countones(c ^ rec) < bd) begin
                bd   = $countones(c ^ rec);
                best = c;
            end
        end
        if (bd == 1) push(m_enc(din), rec, m_syn(rec), ^rec, best, 1'b1, 1'b0);
        else         push(m_enc(din), rec, m_syn(rec), ^rec, rec, 1'b0, bd >= 2);
    endtask

    // Reset leaves zero in every stage register. Stages 2 and 3 will show those
    // zeros until the first captured word reaches them.
    task automatic flush();
        s2_t z2;
        s3_t z3;
        q1.delete(); q2.delete(); q3.delete();
        z2.rec = '0; z2.syn = '0; z2.st = 0; z2.es = 0; z2.ed = 0;
        z3.pc = '0; z3.cor = '0; z3.sd = 0; z3.dd = 0;
        q2.push_back(z2);
        q3.push_back(z3);
        q3.push_back(z3);
    endtask

    task automatic compare();
        s2_t e2;
        s3_t e3;
        if (q1.size() == 0 || q2.size() == 0 || q3.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed %0d expected 1", 0);
            return;
        end
        chk("palabra", 16'(palabra), 16'(q1.pop_front()));
        e2 = q2.pop_front();
        chk("recibido", 16'(recibido), 16'(e2.rec));
        chk("syndrome", 16'({s3, s2, s1}), 16'(e2.syn));
        chk("st_flags", 16'({st, error_simple, error_doble}), 16'({e2.st, e2.es, e2.ed}));
        e3 = q3.pop_front();
        chk("palabra_corregida", 16'(palabra_corregida), 16'(e3.pc));
        chk("corregido", 16'(corregido), 16'(e3.cor));
        chk("s3_flags", 16'({simplerror_detectado, doblerror_detectado, led_doblerror}),
            16'({e3.sd, e3.dd, e3.dd}));
    endtask

    // Drive inputs away from the capture edge, push the expectation at the
    // capture edge, and check at the following negedge.
    task automatic step_lit(input logic [3:0] din, input logic [3:0] derr,
                            input logic [7:0] pal, input logic [7:0] rec, input logic [2:0] syn,
                            input logic stv, input logic [7:0] pc, input logic sd, input logic dd);
        dato_entrada = din;
        dato_error   = derr;
        @(posedge reloj);
        push(pal, rec, syn, stv, pc, sd, dd);
        @(negedge reloj);
        compare();
    endtask

    task automatic step_mod(input logic [3:0] din, input logic [3:0] derr);
        dato_entrada = din;
        dato_error   = derr;
        @(posedge reloj);
        push_model(din, derr);
        @(negedge reloj);
        compare();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 16'({palabra, recibido} != 16'd0), 16'd0);
        chk({tag, "_rest"}, 16'({s1, s2, s3, st, error_simple, error_doble, corregido,
                                 palabra_corregida, simplerror_detectado,
                                 doblerror_detectado, led_doblerror}), 16'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge reloj);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        flush();

        // Known-answer vectors, issued back to back
        step_lit(4'b1010, 4'b1010, 8'hA5, 8'hA5, 3'd0, 1'b0, 8'hA5, 1'b0, 1'b0);
        step_lit(4'b1010, 4'b1011, 8'hA5, 8'hAD, 3'd3, 1'b1, 8'hA5, 1'b1, 1'b0);
        step_lit(4'b0010, 4'b0000, 8'h33, 8'h13, 3'd5, 1'b1, 8'h33, 1'b1, 1'b0);
        step_lit(4'b1101, 4'b1011, 8'hCC, 8'hAC, 3'd3, 1'b0, 8'hAC, 1'b0, 1'b1);
        step_mod(4'b1111, 4'b1111);
        step_mod(4'b0000, 4'b0111);
        step_mod(4'b0110, 4'b1001);

        // Random stream with an arbitrary number of injected errors
        for (int i = 0; i < 40; i++)
            step_mod(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        // Mid-stream asynchronous reset: outputs clear without a clock edge
        dato_entrada = 4'b1101;
        dato_error   = 4'b0101;
        step_mod(4'b1101, 4'b0101);
        step_mod(4'b0111, 4'b0110);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midstream_reset");
        @(posedge reloj);
        @(negedge reloj);
        chk_all_zero("held_reset");
        rst_n = 1'b1;
        flush();

        // Stage 3 stays at zero for two cycles, then shows the first word
        step_lit(4'b1010, 4'b1011, 8'hA5, 8'hAD, 3'd3, 1'b1, 8'hA5, 1'b1, 1'b0);
        step_lit(4'b1101, 4'b1011, 8'hCC, 8'hAC, 3'd3, 1'b0, 8'hAC, 1'b0, 1'b1);
        step_lit(4'b0010, 4'b0000, 8'h33, 8'h13, 3'd5, 1'b1, 8'h33, 1'b1, 1'b0);
        step_mod(4'b0001, 4'b0001);
        step_mod(4'b1000, 4'b0000);
        step_mod(4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_secded_pipeline.md
Name: hamming_secded_pipeline

Overview:
Registered Hamming SEC/DED (8,4) datapath that chains three stages (encode, receive/syndrome, correct) into one block.
- A 4-bit nibble is encoded into an 8-bit codeword.
- The codeword's data bits are replaced by an externally supplied 4-bit "received" nibble to inject errors.
- The received word is decoded: single errors are corrected, double errors are flagged.
- Feeds the board-level 7-segment display and error LEDs.

Parameters:
none (fixed 4 data bits, 3 Hamming parity bits, 1 overall parity bit)

Ports:
reloj  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
dato_entrada  input  4  nibble to encode (transmitted data)
dato_error  input  4  nibble as received; differs from dato_entrada in each bit where an error is injected
palabra  output  8  encoded codeword (stage 1)
recibido  output  8  received codeword (stage 2)
s1  output  1  syndrome bit 0 (stage 2)
s2  output  1  syndrome bit 1 (stage 2)
s3  output  1  syndrome bit 2 (stage 2)
st  output  1  overall-parity check bit (stage 2)
error_simple  output  1  stage-2 single-error flag
error_doble  output  1  stage-2 double-error flag
corregido  output  4  corrected data nibble (stage 3)
palabra_corregida  output  8  corrected codeword (stage 3)
simplerror_detectado  output  1  single error was corrected (stage 3)
doblerror_detectado  output  1  uncorrectable double error (stage 3)
led_doblerror  output  1  LED drive, active high, equals doblerror_detectado

Behaviour:
- Codeword layout: bit i holds Hamming position i for i = 1..7; bit 0 is the overall parity p0.
  - pos1 = p1, pos2 = p2, pos3 = d0, pos4 = p4, pos5 = d1, pos6 = d2, pos7 = d3.
  - d = dato_entrada[3:0].
- Encoding (stage 1, registered):
  - p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3.
  - p0 = XOR of bits 7..1 (even overall parity).
- dato_error is registered in stage 1 alongside palabra so both stay aligned.
- Stage 2 (registered):
  - recibido = palabra with bits 3, 5, 6, 7 replaced by the registered dato_error[0], [1], [2], [3]; parity bits pass through unchanged.
  - s1 = XOR of positions 1, 3, 5, 7; s2 = XOR of positions 2, 3, 6, 7; s3 = XOR of positions 4, 5, 6, 7; st = XOR of all 8 bits.
  - Let syndrome = {s3, s2, s1}.
  - error_simple = st.
  - error_doble = (syndrome != 0) & ~st.
- Stage 3 (registered, from stage-2 values):
  - syndrome = 0, st = 0: word passes unchanged; both flags 0.
  - st = 1, syndrome = k (1..7): flip bit k; simplerror_detectado = 1.
  - st = 1, syndrome = 0: flip bit 0 (p0 error); data unchanged; simplerror_detectado = 1.
  - Double error: no correction; palabra_corregida = recibido; doblerror_detectado = 1; simplerror_detectado = 0.
  - corregido = palabra_corregida bits {7, 6, 5, 3}.
- Timing: fully pipelined, one new nibble accepted every cycle, no handshake.
  - palabra is valid 1 cycle after the input, recibido/syndrome after 2, corrected outputs after 3.
- More than two data-bit errors are decoded by the same rules with no special handling; aliasing is permitted.
- Reset: all registers and outputs clear to 0 asynchronously, including mid-stream. All-zero is a valid codeword, so no flags assert after reset. Reset discards in-flight words.

Test Plan:
- Reset asserted mid-stream -> every output reads 0 immediately; after release, the first valid result appears 3 cycles after the next input.
- dato_entrada=1010, dato_error=1010 -> palabra=8'hA5, recibido=8'hA5, syndrome=0, st=0, corregido=1010, no flags.
- dato_entrada=1010, dato_error=1011 -> recibido=8'hAD, syndrome=3, st=1, palabra_corregida=8'hA5, corregido=1010, simplerror_detectado=1.
- dato_entrada=0010, dato_error=0000 -> palabra=8'h33, recibido=8'h13, syndrome=5, corregido=0010, simplerror_detectado=1.
- dato_entrada=1101, dato_error=1011 -> palabra=8'hCC, recibido=8'hAC, syndrome=3, st=0, corregido=1011, doblerror_detectado=1, led_doblerror=1.
- Back-to-back inputs on consecutive cycles -> results emerge on consecutive cycles in order at latency 3, each with correct flags.
